// File: rtl/exe_div_stage_if.sv
// exe_div_stage_if
//   Pipeline link around the Execute stage: the Decode->Execute offer
//   (DE_valid, de_*), the Execute->Memory offer (EM_valid, em_*) and the
//   two allowin back-pressure signals.
//   slave  : view used by the Execute stage itself.
//   master : view used by the surrounding pipeline (Decode/Memory side).
interface exe_div_stage_if;
    logic        DE_valid;
    logic        E_allowin;
    logic [31:0] de_pc;
    logic [31:0] de_alu_result;
    logic [31:0] de_src1;
    logic [31:0] de_src2;
    logic        de_div_en;
    logic [1:0]  de_div_op;
    logic        de_gr_we;
    logic [4:0]  de_dest;

    logic        M_allowin;
    logic        EM_valid;
    logic [31:0] em_pc;
    logic [31:0] em_result;
    logic        em_gr_we;
    logic [4:0]  em_dest;

    modport slave (
        input  DE_valid, de_pc, de_alu_result, de_src1, de_src2,
               de_div_en, de_div_op, de_gr_we, de_dest, M_allowin,
        output E_allowin, EM_valid, em_pc, em_result, em_gr_we, em_dest
    );

    modport master (
        output DE_valid, de_pc, de_alu_result, de_src1, de_src2,
               de_div_en, de_div_op, de_gr_we, de_dest, M_allowin,
        input  E_allowin, EM_valid, em_pc, em_result, em_gr_we, em_dest
    );
endinterface

// File: rtl/exe_div_stage.sv
// exe_div_stage
//   Execute pipeline stage. Holds the DE->EM pipeline register, passes
//   single-cycle ALU results straight through, and stalls for a 32-step
//   radix-2 restoring divider for div.w / mod.w / div.wu / mod.wu.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   flush_i    kills the instruction held in Execute (exception/ertn)
//   pipe       exe_div_stage_if.slave: DE offer in, EM offer out, allowins
//   div_busy_o high while the divider is iterating
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no divide in progress; ALU ops pass through
// S_CALC | divider iterating, one quotient bit per cycle
// S_DONE | divide result valid, held until it transfers to Memory
module exe_div_stage #(
    parameter int DIV_ITER = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    exe_div_stage_if.slave   pipe,
    output logic             div_busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [5:0] LAST_ITER = 6'(DIV_ITER - 1);

    state_e      state_q, state_d;

    logic        e_valid_q;
    logic [31:0] pc_q;
    logic [31:0] alu_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic        div_en_q;
    logic [1:0]  div_op_q;
    logic        gr_we_q;
    logic [4:0]  dest_q;

    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] dvsr_q;
    logic [5:0]  cnt_q;

    logic        ready_go;
    logic        e_allowin;
    logic        em_valid;
    logic        de_fire;
    logic        em_fire;

    logic        signed_op;
    logic [31:0] abs1, abs2;
    logic [32:0] upper, diff;
    logic        ge;
    logic [31:0] q_fix, r_fix;

    // ---------------- handshake ----------------
    assign ready_go  = !div_en_q || (state_q == S_DONE);
    assign e_allowin = !e_valid_q || (ready_go && pipe.M_allowin);
    assign em_valid  = e_valid_q && ready_go;
    assign de_fire   = pipe.DE_valid && e_allowin && !flush_i;
    assign em_fire   = em_valid && pipe.M_allowin;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e_valid_q <= 1'b0;
            pc_q      <= '0;
            alu_q     <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            div_en_q  <= 1'b0;
            div_op_q  <= '0;
            gr_we_q   <= 1'b0;
            dest_q    <= '0;
        end else begin
            if (flush_i) begin
                e_valid_q <= 1'b0;
            end else if (e_allowin) begin
                e_valid_q <= pipe.DE_valid;
            end
            if (de_fire) begin
                pc_q     <= pipe.de_pc;
                alu_q    <= pipe.de_alu_result;
                src1_q   <= pipe.de_src1;
                src2_q   <= pipe.de_src2;
                div_en_q <= pipe.de_div_en;
                div_op_q <= pipe.de_div_op;
                gr_we_q  <= pipe.de_gr_we;
                dest_q   <= pipe.de_dest;
            end
        end
    end

    // ---------------- divider FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (e_valid_q && div_en_q && !flush_i) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (flush_i || em_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- divider datapath ----------------
    assign signed_op = !div_op_q[1];
    assign abs1 = (signed_op && src1_q[31]) ? (~src1_q + 32'd1) : src1_q;
    assign abs2 = (signed_op && src2_q[31]) ? (~src2_q + 32'd1) : src2_q;

    // Top 33 bits of {rem,quot} after the left shift. rem stays below the
    // divisor (or below 2^k after k steps when dividing by zero), so the
    // restored or subtracted remainder always fits back into 32 bits.
    assign upper = {rem_q, quot_q[31]};
    assign diff  = upper - {1'b0, dvsr_q};
    assign ge    = !diff[32];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (state_q == S_IDLE && state_d == S_CALC) begin
                rem_q  <= '0;
                quot_q <= abs1;
                dvsr_q <= abs2;
                cnt_q  <= '0;
            end else if (state_q == S_CALC) begin
                rem_q  <= ge ? diff[31:0] : upper[31:0];
                quot_q <= {quot_q[30:0], ge};
                cnt_q  <= cnt_q + 6'd1;
            end
        end
    end

    // Divide by zero naturally yields all-ones quotient and the dividend
    // magnitude as remainder; the quotient sign fixup is suppressed so the
    // signed case also reports 0xFFFFFFFF.
    assign q_fix = (signed_op && (src1_q[31] ^ src2_q[31]) && (src2_q != 32'd0))
                   ? (~quot_q + 32'd1) : quot_q;
    assign r_fix = (signed_op && src1_q[31]) ? (~rem_q + 32'd1) : rem_q;

    // ---------------- outputs ----------------
    assign pipe.E_allowin = e_allowin;
    assign pipe.EM_valid  = em_valid;
    assign pipe.em_pc     = pc_q;
    assign pipe.em_result = div_en_q ? (div_op_q[0] ? r_fix : q_fix) : alu_q;
    assign pipe.em_gr_we  = e_valid_q && gr_we_q;
    assign pipe.em_dest   = (e_valid_q && gr_we_q) ? dest_q : 5'd0;
    assign div_busy_o     = (state_q == S_CALC);

endmodule

// File: tb/tb_exe_div_stage.sv
module tb_exe_div_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic div_busy;

    int errors = 0;
    int checks = 0;

    exe_div_stage_if pipe ();

    exe_div_stage #(.DIV_ITER(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .pipe       (pipe.slave),
        .div_busy_o (div_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_de(input logic [31:0] pc, input logic [31:0] alu,
                            input logic [31:0] s1, input logic [31:0] s2,
                            input logic den, input logic [1:0] op,
                            input logic we, input logic [4:0] dest);
        pipe.DE_valid      = 1'b1;
        pipe.de_pc         = pc;
        pipe.de_alu_result = alu;
        pipe.de_src1       = s1;
        pipe.de_src2       = s2;
        pipe.de_div_en     = den;
        pipe.de_div_op     = op;
        pipe.de_gr_we      = we;
        pipe.de_dest       = dest;
    endtask

    // Counts clock edges until EM_valid rises (bounded), and busy cycles seen.
    task automatic wait_em(output int n, output int busy);
        n = 0;
        busy = 0;
        while (!pipe.EM_valid && n < 80) begin
            if (div_busy) busy++;
            step();
            n++;
        end
    endtask

    // Full divide: issue, expect EM_valid 33 cycles after entry, check result,
    // let it transfer and confirm the stage empties.
    task automatic run_div(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [1:0] op, input logic [31:0] exp);
        int n, busy;
        drive_de(32'h1c00_0100, 32'hdead_0000, s1, s2, 1'b1, op, 1'b1, 5'd7);
        step();
        pipe.DE_valid = 1'b0;
        #1;
        wait_em(n, busy);
        chk({tag, "_lat"}, n, 33);
        chk({tag, "_busy"}, busy, 32);
        chk({tag, "_res"}, pipe.em_result, exp);
        chk({tag, "_dest"}, pipe.em_dest, 7);
        step();
        chk({tag, "_out"}, pipe.EM_valid, 0);
        chk({tag, "_idle"}, div_busy, 0);
    endtask

    initial begin
        int n, busy, hits;
        rst = 1'b1;
        flush = 1'b0;
        pipe.M_allowin = 1'b1;
        drive_de(0, 0, 0, 0, 1'b0, 2'b00, 1'b0, 5'd0);
        pipe.DE_valid = 1'b0;
        repeat (3) step();

        chk("rst_allowin", pipe.E_allowin, 1);
        chk("rst_emvalid", pipe.EM_valid, 0);
        chk("rst_pc", pipe.em_pc, 0);
        chk("rst_result", pipe.em_result, 0);
        chk("rst_grwe", pipe.em_gr_we, 0);
        chk("rst_dest", pipe.em_dest, 0);
        chk("rst_busy", div_busy, 0);
        rst = 1'b0;
        step();

        // ALU pass-through, zero added latency
        drive_de(32'h1c00_0000, 32'h1234_5678, 32'h0000_0011, 32'h0000_0022,
                 1'b0, 2'b00, 1'b1, 5'd5);
        step();
        drive_de(32'h1c00_0004, 32'h0bad_beef, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 5'd6);
        #1;
        chk("alu_valid", pipe.EM_valid, 1);
        chk("alu_result", pipe.em_result, 32'h1234_5678);
        chk("alu_dest", pipe.em_dest, 5);
        chk("alu_grwe", pipe.em_gr_we, 1);
        chk("alu_pc", pipe.em_pc, 32'h1c00_0000);
        chk("alu_allowin", pipe.E_allowin, 1);
        step();
        pipe.DE_valid = 1'b0;
        #1;
        chk("alu2_valid", pipe.EM_valid, 1);
        chk("alu2_result", pipe.em_result, 32'h0bad_beef);
        chk("alu2_dest_gated", pipe.em_dest, 0);
        chk("alu2_grwe_gated", pipe.em_gr_we, 0);
        step();
        chk("alu_drain", pipe.EM_valid, 0);

        // Divides
        run_div("divw_m7_2",   32'hFFFF_FFF9, 32'd2, 2'b00, 32'hFFFF_FFFD);
        run_div("modw_m7_2",   32'hFFFF_FFF9, 32'd2, 2'b01, 32'hFFFF_FFFF);
        run_div("divwu_m7_2",  32'hFFFF_FFF9, 32'd2, 2'b10, 32'h7FFF_FFFC);
        run_div("divw_7_m2",   32'd7, 32'hFFFF_FFFE, 2'b00, 32'hFFFF_FFFD);
        run_div("modw_7_m2",   32'd7, 32'hFFFF_FFFE, 2'b01, 32'd1);
        run_div("divw_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000);
        run_div("modw_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 32'd0);
        run_div("modwu_100_0", 32'd100, 32'd0, 2'b11, 32'd100);
        run_div("divwu_5_0",   32'd5, 32'd0, 2'b10, 32'hFFFF_FFFF);
        run_div("divw_m7_0",   32'hFFFF_FFF9, 32'd0, 2'b00, 32'hFFFF_FFFF);
        run_div("modw_m7_0",   32'hFFFF_FFF9, 32'd0, 2'b01, 32'hFFFF_FFF9);

        // Divide completes against a stalled Memory stage
        pipe.M_allowin = 1'b0;
        drive_de(32'h1c00_0200, 32'h0, 32'd100, 32'd7, 1'b1, 2'b10, 1'b1, 5'd3);
        step();
        pipe.DE_valid = 1'b0;
        #1;
        wait_em(n, busy);
        chk("stall_lat", n, 33);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", pipe.EM_valid, 1);
            chk("stall_result", pipe.em_result, 32'd14);
            chk("stall_allowin", pipe.E_allowin, 0);
            chk("stall_busy", div_busy, 0);
            step();
        end
        pipe.M_allowin = 1'b1;
        #1;
        chk("stall_release_allowin", pipe.E_allowin, 1);
        step();
        chk("stall_out", pipe.EM_valid, 0);
        chk("stall_idle", div_busy, 0);

        // Flush at iteration 10
        drive_de(32'h1c00_0300, 32'h0, 32'd1000, 32'd3, 1'b1, 2'b00, 1'b1, 5'd4);
        step();
        pipe.DE_valid = 1'b0;
        #1;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            if (pipe.EM_valid) hits++;
            step();
        end
        chk("flush_busy_before", div_busy, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("flush_valid", pipe.EM_valid, 0);
        chk("flush_allowin", pipe.E_allowin, 1);
        chk("flush_busy", div_busy, 0);
        for (int i = 0; i < 40; i++) begin
            if (pipe.EM_valid) hits++;
            step();
        end
        chk("flush_no_em", hits, 0);
        drive_de(32'h1c00_0400, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 5'd9);
        step();
        pipe.DE_valid = 1'b0;
        #1;
        chk("post_flush_alu_valid", pipe.EM_valid, 1);
        chk("post_flush_alu_result", pipe.em_result, 32'hCAFE_F00D);
        chk("post_flush_alu_dest", pipe.em_dest, 9);
        step();

        // Back-to-back divides
        drive_de(32'h1c00_0500, 32'h0, 32'd9, 32'd3, 1'b1, 2'b10, 1'b1, 5'd10);
        step();
        pipe.DE_valid = 1'b0;
        #1;
        wait_em(n, busy);
        chk("b2b1_lat", n, 33);
        chk("b2b1_result", pipe.em_result, 32'd3);
        drive_de(32'h1c00_0504, 32'h0, 32'd10, 32'd4, 1'b1, 2'b10, 1'b1, 5'd11);
        #1;
        chk("b2b_allowin", pipe.E_allowin, 1);
        step();
        pipe.DE_valid = 1'b0;
        #1;
        chk("b2b2_idle_first", div_busy, 0);
        wait_em(n, busy);
        chk("b2b2_lat", n + 1, 34);
        chk("b2b2_result", pipe.em_result, 32'd2);
        chk("b2b2_dest", pipe.em_dest, 11);
        chk("b2b2_pc", pipe.em_pc, 32'h1c00_0504);
        step();
        chk("b2b2_out", pipe.EM_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
